// File: rtl/adc_seq_pkg.sv
// -----------------------------------------------------------------------------
// adc_seq_pkg
// Shared types and helpers for the ADC SAR conversion sequencer.
//   - state_e    : sequencer state encoding
//   - N_COMP_DEF : default comparisons per conversion (also result width)
//   - SAMP_W_DEF : default width of the sample-window length field
//   - eff_samp() : effective sample-window length (0 behaves as 1)
//   - eff_comp() : effective comparison count (0 or > max behaves as max)
// -----------------------------------------------------------------------------
package adc_seq_pkg;

  localparam int N_COMP_DEF = 16;
  localparam int SAMP_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SAMP,
    COMP,
    UPDATE,
    DONE
  } state_e;

  function automatic int unsigned eff_samp(input int unsigned cycles);
    return (cycles == 0) ? 1 : cycles;
  endfunction

  function automatic int unsigned eff_comp(input int unsigned count,
                                           input int unsigned max_count);
    return (count == 0 || count > max_count) ? max_count : count;
  endfunction

endpackage

// File: rtl/adc_seq_cnt.sv
// -----------------------------------------------------------------------------
// adc_seq_cnt
// Loadable down counter with a zero flag. Load wins over decrement and the
// count never wraps below zero.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset (count -> 0)
//   load     : load load_val this cycle
//   load_val : value to load
//   dec      : decrement by one when non-zero
//   zero     : count is zero
// -----------------------------------------------------------------------------
module adc_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d is given a default before any branch so the combinational
  // block never has a path that leaves it unassigned (which would infer a latch).
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/adc_sequencer.sv
// -----------------------------------------------------------------------------
// adc_sequencer
// Drives the ADC macro's sequencing strobes for one SAR conversion per start
// request: INIT (1 cycle), SAMP (S cycles), then K COMP/UPDATE pairs. The
// comparator decision is shifted in MSB-first at the end of each UPDATE cycle
// and the right-aligned word is offered on a valid/ready handshake.
//
// Optional feature (macro ADC_SEQ_CONT_EN): adds input cont_mode. While it is
// high, DONE goes straight back to INIT, so conversions repeat back to back
// with busy held high between them. Without the macro the block is single-shot.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : conversion request, sampled in IDLE only
//   cfg_samp_cycles     : sample window length S (0 behaves as 1)
//   cfg_comp_cycles     : comparisons K (0 or > N_COMP behaves as N_COMP)
//   comp_out            : comparator decision from the ADC
//   cont_mode           : continuous conversion enable (ADC_SEQ_CONT_EN only)
//   seq_init/samp/comp/update : registered, mutually exclusive phase strobes
//   busy                : conversion in progress
//   result              : captured bits, MSB-first, right-aligned
//   result_valid        : result available, held until accepted
//   result_ready        : consumer accepts result
//   overrun             : sticky, a finished result was dropped
// -----------------------------------------------------------------------------
module adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int N_COMP = N_COMP_DEF,
  parameter int SAMP_W = SAMP_W_DEF,
  parameter int CNT_W  = $clog2(N_COMP + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SAMP_W-1:0] cfg_samp_cycles,
  input  logic [CNT_W-1:0]  cfg_comp_cycles,
  input  logic              comp_out,
`ifdef ADC_SEQ_CONT_EN
  input  logic              cont_mode,
`endif
  output logic              seq_init,
  output logic              seq_samp,
  output logic              seq_comp,
  output logic              seq_update,
  output logic              busy,
  output logic [N_COMP-1:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              overrun
);

  state_e state_q, state_d;

  logic              cont_w;
  logic              cont_q, cont_d;
  logic [N_COMP-1:0] shift_q, shift_d, shift_in;
  logic [N_COMP-1:0] result_q, result_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              seq_init_q, seq_samp_q, seq_comp_q, seq_update_q, busy_q;
  logic              busy_d;

  logic              cnt_load;
  logic              samp_zero, comp_zero;
  logic [SAMP_W-1:0] samp_load_val;
  logic [CNT_W-1:0]  comp_load_val;
  logic              completion, handshake;

`ifdef ADC_SEQ_CONT_EN
  assign cont_w = cont_mode;
`else
  assign cont_w = 1'b0;
`endif

  // Counters are loaded with (length - 1) on the edge that enters INIT, which
  // is the only point where the configuration is sampled.
  assign cnt_load      = (state_d == INIT);
  assign samp_load_val = SAMP_W'(eff_samp(32'(cfg_samp_cycles)) - 1);
  assign comp_load_val = CNT_W'(eff_comp(32'(cfg_comp_cycles), 32'(N_COMP)) - 1);

  adc_seq_cnt #(.W(SAMP_W)) u_samp_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (samp_load_val),
    .dec      (state_q == SAMP),
    .zero     (samp_zero)
  );

  adc_seq_cnt #(.W(CNT_W)) u_comp_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (comp_load_val),
    .dec      (state_q == UPDATE),
    .zero     (comp_zero)
  );

  assign shift_in   = {shift_q[N_COMP-2:0], comp_out};
  assign completion = (state_q == UPDATE) && comp_zero;
  assign handshake  = valid_q && result_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = INIT;
      INIT:    state_d = SAMP;
      SAMP:    if (samp_zero) state_d = COMP;
      COMP:    state_d = UPDATE;
      UPDATE:  state_d = comp_zero ? DONE : COMP;
      DONE:    state_d = cont_q ? INIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d   = shift_q;
    result_d  = result_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    cont_d    = cont_q;

    if (state_q == INIT) begin
      shift_d = '0;
    end else if (state_q == UPDATE) begin
      shift_d = shift_in;
    end

    if (handshake) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    // A finished word loads only if the output slot is empty or being drained
    // this very cycle; otherwise it is dropped and the old word is kept.
    if (completion) begin
      cont_d = cont_w;
      if (!valid_q || handshake) begin
        result_d = shift_in;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Strobes and busy are decoded from the next state and registered, so the
  // pins come straight from flops and are glitch-free. busy stays high through
  // DONE only when another conversion follows immediately.
  assign busy_d = (state_d inside {INIT, SAMP, COMP, UPDATE}) ||
                  (state_d == DONE && cont_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cont_q       <= 1'b0;
      shift_q      <= '0;
      result_q     <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      seq_init_q   <= 1'b0;
      seq_samp_q   <= 1'b0;
      seq_comp_q   <= 1'b0;
      seq_update_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cont_q       <= cont_d;
      shift_q      <= shift_d;
      result_q     <= result_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      seq_init_q   <= (state_d == INIT);
      seq_samp_q   <= (state_d == SAMP);
      seq_comp_q   <= (state_d == COMP);
      seq_update_q <= (state_d == UPDATE);
      busy_q       <= busy_d;
    end
  end

  assign seq_init     = seq_init_q;
  assign seq_samp     = seq_samp_q;
  assign seq_comp     = seq_comp_q;
  assign seq_update   = seq_update_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_sequencer
// Directed bench for adc_sequencer. Expected result words are queued when a
// conversion is started and popped into a small output model (valid, result,
// overrun) at the edge where the conversion completes. Strobe timing is
// re-derived per cycle from S and K. Build with ADC_SEQ_CONT_EN to also cover
// continuous mode.
// -----------------------------------------------------------------------------
module tb_adc_sequencer;

  localparam int N  = 16;
  localparam int SW = 8;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [SW-1:0] cfg_samp_cycles;
  logic [CW-1:0] cfg_comp_cycles;
  logic          comp_out;
  logic          seq_init, seq_samp, seq_comp, seq_update, busy;
  logic [N-1:0]  result;
  logic          result_valid;
  logic          result_ready;
  logic          overrun;
`ifdef ADC_SEQ_CONT_EN
  logic          cont_mode = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [N-1:0] sb[$];
  logic         m_valid   = 1'b0;
  logic         m_overrun = 1'b0;
  logic [N-1:0] m_result  = '0;

  always #5 clk = ~clk;

  adc_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_samp_cycles (cfg_samp_cycles),
    .cfg_comp_cycles (cfg_comp_cycles),
    .comp_out        (comp_out),
`ifdef ADC_SEQ_CONT_EN
    .cont_mode       (cont_mode),
`endif
    .seq_init        (seq_init),
    .seq_samp        (seq_samp),
    .seq_comp        (seq_comp),
    .seq_update      (seq_update),
    .busy            (busy),
    .result          (result),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .overrun         (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {init, samp, comp, update, busy} expected in cycle c after the start edge.
  function automatic logic [4:0] exp_ph(input int c, input int s, input int k);
    logic [4:0] r;
    r = '0;
    if (c == 1) r[4] = 1'b1;
    else if (c >= 2 && c <= s + 1) r[3] = 1'b1;
    else if (c >= s + 2 && c <= s + 1 + 2 * k) begin
      if (((c - s - 2) % 2) == 0) r[2] = 1'b1;
      else r[1] = 1'b1;
    end
    if (c >= 1 && c <= s + 1 + 2 * k) r[0] = 1'b1;
    return r;
  endfunction

  task automatic check_outputs(input string tag, input logic [4:0] ph);
    check({tag, " init"},    seq_init,     ph[4]);
    check({tag, " samp"},    seq_samp,     ph[3]);
    check({tag, " comp"},    seq_comp,     ph[2]);
    check({tag, " update"},  seq_update,   ph[1]);
    check({tag, " busy"},    busy,         ph[0]);
    check({tag, " valid"},   result_valid, m_valid);
    check({tag, " result"},  result,       m_result);
    check({tag, " overrun"}, overrun,      m_overrun);
  endtask

  // Advance the output model across one edge, then move to 1 time unit after it.
  task automatic step(input bit completes);
    logic         was_valid;
    logic         hs;
    logic [N-1:0] exp;
    was_valid = m_valid;
    hs        = m_valid && result_ready;
    if (hs) begin
      m_valid   = 1'b0;
      m_overrun = 1'b0;
    end
    if (completes && sb.size() != 0) begin
      exp = sb.pop_front();
      if (!was_valid || hs) begin
        m_result = exp;
        m_valid  = 1'b1;
      end else begin
        m_overrun = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // One full conversion with per-cycle checks. disturb pulses start and
  // rewrites cfg mid-conversion; hs_cycle (non-zero) raises ready in that
  // cycle only, otherwise result_ready is left as the caller set it.
  task automatic run_conv(input int s_cfg, input int k_cfg, input logic [N-1:0] bits,
                          input bit disturb, input int hs_cycle);
    int          s, k, last, idx;
    logic [31:0] mask;
    logic [4:0]  ph;
    s    = (s_cfg == 0) ? 1 : s_cfg;
    k    = (k_cfg == 0 || k_cfg > N) ? N : k_cfg;
    last = s + 2 + 2 * k;
    mask = (32'd1 << k) - 32'd1;
    cfg_samp_cycles = SW'(s_cfg);
    cfg_comp_cycles = CW'(k_cfg);
    start = 1'b1;
    sb.push_back(bits & mask[N-1:0]);
    step(1'b0);
    start = 1'b0;
    for (int c = 1; c <= last + 1; c++) begin
      if (disturb && c == 5) begin
        start = 1'b1;
        cfg_samp_cycles = 8'd7;
        cfg_comp_cycles = 5'd3;
      end
      if (disturb && c == 6) start = 1'b0;
      if (hs_cycle != 0) result_ready = (c == hs_cycle);
      ph = exp_ph(c, s, k);
      if (ph[1]) begin
        idx = k - 1 - (c - s - 3) / 2;
        comp_out = bits[idx];
      end else begin
        comp_out = 1'($urandom);
      end
      check_outputs($sformatf("s%0d k%0d c%0d", s, k, c), ph);
      if (c <= last) step(c == last - 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_samp_cycles = '0;
    cfg_comp_cycles = '0;
    comp_out = 1'b0;
    result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs("reset", 5'b0);

    // Basic conversion: S=2, K=4, bits 1,0,1,1 -> 0x000B, valid in cycle 12.
    run_conv(2, 4, 16'h000B, 1'b0, 0);
    // Zero configuration clamps to S=1, K=16; valid in cycle 35.
    run_conv(0, 0, 16'hFFFF, 1'b0, 0);
    // K above N_COMP clamps to N_COMP.
    run_conv(3, 20, 16'hA5C3, 1'b0, 0);
    // start and cfg changes while busy have no effect.
    run_conv(2, 4, 16'h0009, 1'b1, 0);

    // Two conversions without acceptance: first kept, second dropped, overrun.
    result_ready = 1'b0;
    run_conv(2, 4, 16'h0005, 1'b0, 0);
    run_conv(1, 3, 16'h0006, 1'b0, 0);
    result_ready = 1'b1;
    step(1'b0);
    check_outputs("after handshake", 5'b0);

    // Handshake in the completion cycle: new word loads, valid stays high.
    result_ready = 1'b0;
    run_conv(1, 2, 16'h0002, 1'b0, 0);
    run_conv(1, 2, 16'h0001, 1'b0, 1 + 1 + 2 * 2);

    // Reset during the third COMP (cycle 8 with S=2, K=4) aborts everything.
    cfg_samp_cycles = 8'd2;
    cfg_comp_cycles = 5'd4;
    start = 1'b1;
    step(1'b0);
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      comp_out = 1'($urandom);
      check_outputs($sformatf("pre-rst c%0d", c), exp_ph(c, 2, 4));
      if (c < 8) step(1'b0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_valid = 1'b0;
    m_overrun = 1'b0;
    m_result = '0;
    sb.delete();
    check_outputs("mid reset", 5'b0);
    result_ready = 1'b1;
    run_conv(2, 4, 16'h000D, 1'b0, 0);

`ifdef ADC_SEQ_CONT_EN
    // Continuous mode, S=1, K=2: period 7, dropping cont_mode ends after conv 2.
    begin
      logic [1:0] cbits[2];
      logic [4:0] ph;
      int         conv, l;
      cbits[0] = 2'b10;
      cbits[1] = 2'b01;
      sb.push_back(16'h0002);
      sb.push_back(16'h0001);
      cont_mode = 1'b1;
      cfg_samp_cycles = 8'd1;
      cfg_comp_cycles = 5'd2;
      start = 1'b1;
      step(1'b0);
      start = 1'b0;
      for (int a = 1; a <= 16; a++) begin
        conv = (a - 1) / 7;
        l    = (a - 1) % 7 + 1;
        if (a == 10) cont_mode = 1'b0;
        ph = (conv < 2) ? exp_ph(l, 1, 2) : 5'b0;
        if (conv == 0 && l == 7) ph[0] = 1'b1;
        if (ph[1]) comp_out = cbits[conv][1 - (l - 4) / 2];
        else comp_out = 1'($urandom);
        check_outputs($sformatf("cont a%0d", a), ph);
        step(conv < 2 && l == 5);
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
